uart_tx_dev: RTL and testbench
==============================

Name: uart_tx_dev

Overview:
- Memory-mapped serial transmitter peripheral; the output-direction counterpart to the keypad input device on the same processor bus.
- The CPU writes bytes to a data register; they queue in a small FIFO and are shifted out on TXD as 8N1 frames.
- A control/status register exposes ready, overrun, busy, flush, interrupt-enable and FIFO count.
- IRQ tells the CPU that FIFO space is available.

Parameters:
BITS, 32, bus data/address width
BASE, 32'hFFFF0100 + 32'h100 = 32'hFFFF0200, data register address; control register at BASE+4
CLKDIV, 16, CLK cycles per serial bit (>=2)
DEPTH, 4, FIFO entries (power of 2, >=2)

Ports:
CLK  in  1  clock
RESET  in  1  reset, asynchronous, active-high
ADDRBUS  in  BITS  bus address
DATABUS  inout  BITS  bus data; driven only during reads of this device, else Z
WE  in  1  bus write enable (1=write, 0=read)
TXD  out  1  serial output, idle high
IRQ  out  1  interrupt request, level

Behaviour:
- Reset: FIFO empty, count=0, overrun=0, IE=0, FSM=IDLE, TXD=1, IRQ=0, DATABUS=Z. Reset asserted mid-frame forces TXD=1 immediately and discards the frame and the FIFO.
- Decode: dataSel = ADDRBUS==BASE; ctrlSel = ADDRBUS==BASE+4.
- Bus reads are combinational.
  - Data reg read: {24'b0, last byte written}.
  - Control read: bit0 ready (count<DEPTH); bit1 overrun; bit2 busy (FSM!=IDLE or count!=0); bit3 0; bit4 IE; bits[11:8] count; all other bits 0.
- Data write (WE && dataSel, at posedge):
  - Not full: push DATABUS[7:0] and update the last-written byte.
  - Full: data dropped, overrun<=1, last-written byte unchanged.
  - Fullness is evaluated on the count before any same-cycle pop, so a write to a full FIFO is dropped even if a pop occurs that cycle.
- Control write (WE && ctrlSel):
  - IE<=DATABUS[4].
  - DATABUS[1]==0 clears overrun.
  - DATABUS[3]==1 flushes the FIFO (count<=0). The frame in flight completes.
  - Bits 0 and 2 are read-only and ignored on write.
  - Flush plus a same-cycle pop: result is count=0.
- IRQ = IE && ready.
- FIFO: circular, head/tail pointers of log2(DEPTH) bits wrap modulo DEPTH, with count 0..DEPTH.
  - Simultaneous accepted push and pop: count unchanged.
- Shifter FSM with states IDLE, START, DATA, STOP; bit counter 0..7; baud counter 0..CLKDIV-1.
  - IDLE: TXD=1. If count!=0, pop head into the shift register, baud<=0, go to START. The transition happens at the same edge, so TXD=0 is visible one cycle after the pushing write edge.
  - START: TXD=0 for CLKDIV cycles, then go to DATA with bit=0.
  - DATA: TXD=shift[0] for CLKDIV cycles per bit, LSB first. Shift right after each bit; after bit 7 go to STOP.
  - STOP: TXD=1 for CLKDIV cycles, then go to IDLE.
  - IDLE lasts at least one cycle, so back-to-back frames are separated by exactly 1 extra idle cycle. Frame period = 10*CLKDIV+1 cycles.
- TXD is registered (no glitches).
- DATABUS writes to non-matching addresses have no effect.

Test Plan:
- Reset → TXD=1, IRQ=0, control read = 32'h0000_0001 (ready=1, count=0).
- CLKDIV=4: write 8'hA5 to BASE → TXD low starting 1 cycle later for 4 cycles. Then 1,0,1,0,0,1,0,1 (4 cycles each), then stop high for 4 cycles. busy=1 throughout, 0 after STOP→IDLE.
- DEPTH=4: six back-to-back writes 8'h01..8'h06 while the first frame is shifting. The first is popped immediately; 01..05 are accepted; the sixth write finds count=4 and is dropped. Control read shows overrun=1, ready=0, count=4. Bytes 01..05 are transmitted in order with a 1-cycle gap between frames.
- With overrun=1: write 32'h0000_0012 to control → IE=1, overrun stays 1. Then write 32'h0000_0010 → overrun=0. IRQ=1 whenever count<4, and 0 when the FIFO is full.
- Fill the FIFO with 3 bytes mid-frame, then write control 32'h0000_0018 → count=0. The current frame finishes intact, and TXD stays 1 afterwards.
- Assert RESET mid-DATA → TXD=1 asynchronously, control read = 32'h0000_0001, and no further frames are sent after deassertion.

Source files
------------

// File: rtl/uart_tx_dev.sv
// -----------------------------------------------------------------------------
// uart_tx_dev - memory-mapped 8N1 serial transmitter
//
// The CPU writes bytes to the data register at BASE.  They queue in a small
// circular FIFO and are shifted out on TXD as 8N1 frames, CLKDIV clocks per
// bit.  The control/status register at BASE+4 reports ready, overrun, busy,
// interrupt-enable and the FIFO fill count, and accepts IE, overrun-clear and
// flush commands.  IRQ is raised while IE is set and the FIFO has space.
//
// Ports:
//   CLK      in     clock
//   RESET    in     asynchronous active-high reset
//   ADDRBUS  in     bus address (BITS wide)
//   DATABUS  inout  bus data; driven only while this device is read, else Z
//   WE       in     1 = bus write, 0 = bus read
//   TXD      out    registered serial output, idles high
//   IRQ      out    level interrupt: IE && FIFO not full
// -----------------------------------------------------------------------------
module uart_tx_dev #(
    parameter int              BITS   = 32,
    parameter logic [BITS-1:0] BASE   = 32'hFFFF0200,
    parameter int              CLKDIV = 16,
    parameter int              DEPTH  = 4
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [BITS-1:0] ADDRBUS,
    inout  wire  [BITS-1:0] DATABUS,
    input  logic            WE,
    output logic            TXD,
    output logic            IRQ
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;
    localparam logic [BITS-1:0] CTRL_ADDR = BASE + BITS'(4);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    // Bus decode
    logic data_sel, ctrl_sel, data_wr, ctrl_wr;
    assign data_sel = (ADDRBUS == BASE);
    assign ctrl_sel = (ADDRBUS == CTRL_ADDR);
    assign data_wr  = WE && data_sel;
    assign ctrl_wr  = WE && ctrl_sel;

    // Only the low byte and a few control bits are ever consumed on writes.
    logic unused_bus_bits;
    assign unused_bus_bits = ^DATABUS[BITS-1:8];

    // FIFO and control state
    logic [7:0]    fifo_mem [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          ie_q, ie_d;
    logic [7:0]    last_q, last_d;

    // Shifter state
    state_t        state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          txd_q;

    logic full, push, pop, flush, baud_last;

    // Fullness uses the pre-pop count, so a write to a full FIFO is dropped
    // even when the shifter pops in the same cycle.
    assign full      = (count_q == CW'(DEPTH));
    assign push      = data_wr && !full;
    assign pop       = (state_q == ST_IDLE) && (count_q != '0);
    assign flush     = ctrl_wr && DATABUS[3];
    assign baud_last = (baud_q == BW'(CLKDIV - 1));

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        ie_d      = ie_q;
        last_d    = last_q;

        if (push) begin
            tail_d = tail_q + 1'b1;
            last_d = DATABUS[7:0];
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (data_wr && full) begin
            overrun_d = 1'b1;
        end
        if (ctrl_wr) begin
            ie_d = DATABUS[4];
            if (!DATABUS[1]) begin
                overrun_d = 1'b0;
            end
        end
        // A flush cannot coincide with a push (different addresses), so the
        // queue is emptied by snapping head onto tail; a same-cycle pop still
        // hands its byte to the shifter.
        if (flush) begin
            head_d  = tail_q;
            count_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[tail_q] <= DATABUS[7:0];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            ie_q      <= 1'b0;
            last_q    <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            ie_q      <= ie_d;
            last_q    <= last_d;
        end
    end

    // Shifter FSM.  TXD is loaded with the level of the bit that the next
    // CLKDIV cycles will present, so it changes exactly on bit boundaries.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    txd_q <= 1'b1;
                    if (pop) begin
                        shift_q <= fifo_mem[head_q];
                        baud_q  <= '0;
                        txd_q   <= 1'b0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        txd_q   <= shift_q[0];
                        state_q <= ST_DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            txd_q   <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

    // Combinational read mux
    logic [BITS-1:0] rd_data;
    always_comb begin
        rd_data = '0;
        if (data_sel) begin
            rd_data[7:0] = last_q;
        end else if (ctrl_sel) begin
            rd_data[0]       = !full;
            rd_data[1]       = overrun_q;
            rd_data[2]       = (state_q != ST_IDLE) || (count_q != '0);
            rd_data[4]       = ie_q;
            rd_data[8 +: CW] = count_q;
        end
    end

    assign DATABUS = (!WE && (data_sel || ctrl_sel)) ? rd_data : {BITS{1'bz}};
    assign TXD     = txd_q;
    assign IRQ     = ie_q && !full;

endmodule

// File: tb/tb_uart_tx_dev.sv
module tb_uart_tx_dev;
    localparam int          CLKDIV = 4;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] BASE   = 32'hFFFF0200;
    localparam logic [31:0] CTRL   = 32'hFFFF0204;
    localparam int          FRAME  = 10 * CLKDIV + 1;  // start-to-start period
    localparam int          ACTIVE = 10 * CLKDIV;      // cycles the shifter is non-idle

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        WE = 1'b0;
    logic        drv = 1'b0;
    logic [31:0] ADDRBUS = '0;
    logic [31:0] bus_data = '0;
    wire  [31:0] DATABUS;
    wire         TXD;
    wire         IRQ;

    assign DATABUS = drv ? bus_data : 'z;

    uart_tx_dev #(.BITS(32), .BASE(BASE), .CLKDIV(CLKDIV), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET), .ADDRBUS(ADDRBUS), .DATABUS(DATABUS),
        .WE(WE), .TXD(TXD), .IRQ(IRQ)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model: every accepted byte gets the cycle at which its start
    // bit must begin: one cycle after its write, or one frame after the
    // previous byte, whichever is later.
    typedef struct {
        logic [7:0] b;
        int         start;
    } exp_t;
    exp_t exp_q[$];
    int   hist[$];
    int   last_start = -1000;
    bit   m_ie = 0, m_ovr = 0;
    logic [7:0] m_last = '0;
    bit   abort = 0, mon_busy = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // bytes still waiting in the FIFO just before edge e
    function automatic int fifo_cnt(input int e);
        int n = 0;
        foreach (hist[i]) if (hist[i] >= e) n++;
        return n;
    endfunction

    function automatic bit model_busy(input int c);
        foreach (hist[i]) if (hist[i] + ACTIVE > c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_ctrl(input int c);
        logic [31:0] v = '0;
        int cnt = fifo_cnt(c + 1);
        v[0]    = (cnt < DEPTH);
        v[1]    = m_ovr;
        v[2]    = model_busy(c);
        v[4]    = m_ie;
        v[11:8] = 4'(cnt);
        return v;
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output int w);
        @(negedge CLK);
        ADDRBUS = a; bus_data = d; drv = 1'b1; WE = 1'b1;
        @(posedge CLK);
        #1;
        w = cyc;
        WE = 1'b0; drv = 1'b0; ADDRBUS = '0;
    endtask

    task automatic write_data(input logic [7:0] d);
        int w, s;
        bus_write(BASE, {24'h0, d}, w);
        if (fifo_cnt(w) >= DEPTH) begin
            m_ovr = 1'b1;
        end else begin
            s = (w + 1 > last_start + FRAME) ? w + 1 : last_start + FRAME;
            exp_q.push_back('{b: d, start: s});
            hist.push_back(s);
            last_start = s;
            m_last = d;
        end
        $display("write data %h at cycle %0d", d, w);
    endtask

    task automatic write_ctrl(input logic [31:0] d);
        int w;
        exp_t keep[$];
        int   hkeep[$];
        bus_write(CTRL, d, w);
        m_ie = d[4];
        if (!d[1]) m_ovr = 1'b0;
        if (d[3]) begin
            foreach (exp_q[i]) if (exp_q[i].start <= w) keep.push_back(exp_q[i]);
            foreach (hist[i]) if (hist[i] <= w) hkeep.push_back(hist[i]);
            exp_q = keep;
            hist = hkeep;
            last_start = -1000;
            foreach (hist[i]) if (hist[i] > last_start) last_start = hist[i];
        end
        $display("write ctrl %h at cycle %0d", d, w);
    endtask

    task automatic read_ctrl(input string name);
        logic [31:0] e;
        @(negedge CLK);
        ADDRBUS = CTRL; WE = 1'b0; drv = 1'b0;
        #1;
        e = exp_ctrl(cyc);
        check(name, DATABUS, e);
        check({name, "_irq"}, {31'h0, IRQ}, {31'h0, m_ie && (e[0] == 1'b1)});
        $display("read ctrl %s: %h at cycle %0d", name, DATABUS, cyc);
        ADDRBUS = '0;
    endtask

    task automatic read_data(input string name);
        @(negedge CLK);
        ADDRBUS = BASE; WE = 1'b0; drv = 1'b0;
        #1;
        check(name, DATABUS, {24'h0, m_last});
        $display("read data %s: %h", name, DATABUS);
        ADDRBUS = '0;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || mon_busy) && t < 3000) begin
            @(negedge CLK);
            t++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: a plain UART receiver sampling mid-bit, scoring against the queue.
    initial begin : monitor
        logic       prev;
        logic [7:0] got;
        logic       sb, pb;
        int         st;
        exp_t       e;
        prev = 1'b1;
        forever begin
            @(negedge CLK);
            if (TXD == 1'b0 && prev == 1'b1 && !RESET) begin
                mon_busy = 1'b1;
                st = cyc;
                repeat (CLKDIV / 2) @(negedge CLK);
                sb = TXD;
                for (int i = 0; i < 8; i++) begin
                    repeat (CLKDIV) @(negedge CLK);
                    got[i] = TXD;
                end
                repeat (CLKDIV) @(negedge CLK);
                pb = TXD;
                if (!abort) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got byte %h at cycle %0d, required none", got, st);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_data", {24'h0, got}, {24'h0, e.b});
                        check("frame_start", st, e.start);
                        check("start_bit", {31'h0, sb}, 32'h0);
                        check("stop_bit", {31'h0, pb}, 32'h1);
                        $display("frame rx %h start cycle %0d (expected %h @ %0d)", got, st, e.b, e.start);
                    end
                end
                prev = TXD;
                mon_busy = 1'b0;
            end else begin
                prev = TXD;
            end
        end
    end

    initial begin : stimulus
        int t, s, lows, gap;
        logic [31:0] a;

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_txd", {31'h0, TXD}, 32'h1);
        check("rst_irq", {31'h0, IRQ}, 32'h0);
        RESET = 1'b0;
        read_ctrl("rst_ctrl");
        read_data("rst_data");

        // Single frame 0xA5
        write_data(8'hA5);
        read_ctrl("a5_busy");
        repeat (20) @(negedge CLK);
        read_ctrl("a5_mid");
        wait_drain("a5_drain");
        repeat (4) @(negedge CLK);
        read_ctrl("a5_idle");

        // Burst of six: fifth fills the FIFO, sixth overruns
        for (int i = 1; i <= 6; i++) write_data(8'(i));
        read_ctrl("burst_full");
        read_data("burst_last");

        // IE set with overrun kept, then overrun cleared
        write_ctrl(32'h0000_0012);
        read_ctrl("ie_set");
        write_ctrl(32'h0000_0010);
        read_ctrl("ovr_clr");
        for (int k = 0; k < 25; k++) begin
            repeat (6) @(negedge CLK);
            read_ctrl("drain_irq");
        end
        wait_drain("burst_drain");

        // Randomized traffic with stray writes to other addresses
        for (int n = 0; n < 16; n++) begin
            gap = $urandom_range(0, 45);
            repeat (gap) @(negedge CLK);
            write_data(8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                a = $urandom;
                if (a == BASE || a == CTRL) a = BASE + 32'd8;
                bus_write(a, $urandom, t);
                read_data("stray_write");
            end
            if ($urandom_range(0, 2) == 0) read_ctrl("rand_ctrl");
        end
        wait_drain("rand_drain");
        repeat (4) @(negedge CLK);
        read_ctrl("rand_idle");

        // Flush mid-frame
        write_data(8'h3C);
        repeat (8) @(negedge CLK);
        write_data(8'h11);
        write_data(8'h22);
        write_data(8'h33);
        read_ctrl("pre_flush");
        write_ctrl(32'h0000_0018);
        read_ctrl("post_flush");
        wait_drain("flush_drain");
        repeat (60) @(negedge CLK);
        read_ctrl("flush_idle");

        // Reset in the middle of the data bits
        write_data(8'h00);
        write_data(8'h77);
        s = last_start - FRAME;
        t = 0;
        while (cyc < s + 10 && t < 200) begin
            @(negedge CLK);
            t++;
        end
        check("reach_data_phase", {31'h0, TXD}, 32'h0);
        abort = 1'b1;
        #2;
        RESET = 1'b1;
        #1;
        check("async_txd", {31'h0, TXD}, 32'h1);
        exp_q.delete();
        hist.delete();
        last_start = -1000;
        m_ie = 0; m_ovr = 0; m_last = '0;
        @(negedge CLK);
        RESET = 1'b0;
        read_ctrl("post_reset");
        read_data("post_reset_data");
        t = 0;
        while (mon_busy && t < 200) begin
            @(negedge CLK);
            t++;
        end
        check("monitor_settle", {31'h0, mon_busy}, 32'h0);
        abort = 1'b0;
        lows = 0;
        repeat (100) begin
            @(negedge CLK);
            if (TXD == 1'b0) lows++;
        end
        check("quiet_after_reset", lows, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
